// File: rtl/pad_ai_controller.sv
// Right-paddle AI controller.
// Samples the ball on every timing_tick and works out which way the ball is
// moving horizontally. Once the ball approaches in the right half of the
// screen, the controller waits a reaction delay, then chases the ball centre
// at a limited speed. When the ball moves away, the paddle returns to the
// centred home position.
module pad_ai_controller #(
    parameter int SCREEN_H    = 768,
    parameter int PAD_HEIGHT  = 145,
    parameter int BALL_SIZE   = 15,
    parameter int PAD_SPEED   = 3,
    parameter int REACT_TICKS = 8,
    parameter int DEAD_ZONE   = 4,
    parameter int X_TRACK_MIN = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic [10:0] x_ball,
    input  logic [10:0] y_ball,
    output logic [9:0]  y_pad,
    output logic [1:0]  ai_state
);

    localparam logic [1:0] ST_HOME  = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_TRACK = 2'b10;

    localparam int Y_MAX  = SCREEN_H - PAD_HEIGHT;
    localparam int HOME_Y = Y_MAX / 2;
    localparam int CW     = (REACT_TICKS > 1) ? $clog2(REACT_TICKS) : 1;

    localparam logic [9:0]         HOME_Y_U  = 10'(HOME_Y);
    localparam logic signed [11:0] HOME_Y_S  = 12'(HOME_Y);
    localparam logic signed [11:0] Y_MAX_S   = 12'(Y_MAX);
    localparam logic signed [11:0] SPEED_S   = 12'(PAD_SPEED);
    localparam logic signed [11:0] DZ_S      = 12'(DEAD_ZONE);
    localparam logic signed [11:0] TGT_OFS_S = 12'(BALL_SIZE / 2 - PAD_HEIGHT / 2);
    localparam logic [10:0]        X_MIN_U   = 11'(X_TRACK_MIN);
    localparam logic [CW-1:0]      CNT_LOAD  = CW'(REACT_TICKS - 1);
    localparam logic [CW-1:0]      CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]      CNT_ONE   = CW'(1);

    // Step a position toward a goal by at most PAD_SPEED, holding inside dz.
    function automatic logic [9:0] step_toward(
        input logic [9:0]         pos,
        input logic signed [11:0] goal,
        input logic signed [11:0] dz
    );
        logic signed [11:0] pos_s;
        logic signed [11:0] err;
        logic signed [11:0] mag;
        logic signed [11:0] stp;
        logic signed [11:0] res;
        pos_s = $signed({2'b00, pos});
        err   = goal - pos_s;
        mag   = (err < 12'sd0) ? -err : err;
        stp   = (mag < SPEED_S) ? mag : SPEED_S;
        if (mag <= dz) begin
            res = pos_s;
        end else if (err < 12'sd0) begin
            res = pos_s - stp;
        end else begin
            res = pos_s + stp;
        end
        return 10'(res);
    endfunction

    logic [1:0]         state_r;
    logic [1:0]         state_nx_s;
    logic [9:0]         y_pad_r;
    logic [9:0]         y_pad_nx_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_nx_s;
    logic [10:0]        x_prev_r;
    logic               prev_valid_r;
    logic               approaching_r;
    logic               approaching_s;
    logic               trk_s;
    logic signed [11:0] target_raw_s;
    logic signed [11:0] target_s;

    // Direction seen on this tick's sample; equal x keeps the old verdict.
    always_comb begin
        approaching_s = approaching_r;
        if (!prev_valid_r) begin
            approaching_s = approaching_r;
        end else if (x_ball > x_prev_r) begin
            approaching_s = 1'b1;
        end else if (x_ball < x_prev_r) begin
            approaching_s = 1'b0;
        end else begin
            approaching_s = approaching_r;
        end
        trk_s = approaching_s && (x_ball >= X_MIN_U);
    end

    // Paddle target centred on the ball, clamped to the legal paddle range.
    always_comb begin
        target_raw_s = $signed({1'b0, y_ball}) + TGT_OFS_S;
        if (target_raw_s < 12'sd0) begin
            target_s = 12'sd0;
        end else if (target_raw_s > Y_MAX_S) begin
            target_s = Y_MAX_S;
        end else begin
            target_s = target_raw_s;
        end
    end

    // State register, advanced only on tick edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_HOME;
        end else if (timing_tick) begin
            state_r <= state_nx_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state decision for HOME/WAIT/TRACK.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_HOME: begin
                if (trk_s) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_HOME;
                end
            end
            ST_WAIT: begin
                if (!trk_s) begin
                    state_nx_s = ST_HOME;
                end else if (cnt_r == CNT_ZERO) begin
                    state_nx_s = ST_TRACK;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_TRACK: begin
                if (!trk_s) begin
                    state_nx_s = ST_HOME;
                end else begin
                    state_nx_s = ST_TRACK;
                end
            end
            default: state_nx_s = ST_HOME;
        endcase
    end

    // Paddle movement and reaction counter for the current state.
    always_comb begin
        y_pad_nx_s = y_pad_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_HOME: begin
                y_pad_nx_s = step_toward(y_pad_r, HOME_Y_S, 12'sd0);
                if (trk_s) begin
                    cnt_nx_s = CNT_LOAD;
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            ST_WAIT: begin
                y_pad_nx_s = y_pad_r;
                if (!trk_s) begin
                    cnt_nx_s = CNT_ZERO;
                end else if (cnt_r == CNT_ZERO) begin
                    cnt_nx_s = cnt_r;
                end else begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end
            end
            ST_TRACK: begin
                cnt_nx_s = cnt_r;
                if (!trk_s) begin
                    y_pad_nx_s = step_toward(y_pad_r, HOME_Y_S, 12'sd0);
                end else begin
                    y_pad_nx_s = step_toward(y_pad_r, target_s, DZ_S);
                end
            end
            default: begin
                y_pad_nx_s = y_pad_r;
                cnt_nx_s   = CNT_ZERO;
            end
        endcase
    end

    // Datapath registers: paddle, counter and direction history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_pad_r       <= HOME_Y_U;
            cnt_r         <= CNT_ZERO;
            x_prev_r      <= 11'd0;
            prev_valid_r  <= 1'b0;
            approaching_r <= 1'b0;
        end else if (timing_tick) begin
            y_pad_r       <= y_pad_nx_s;
            cnt_r         <= cnt_nx_s;
            x_prev_r      <= x_ball;
            prev_valid_r  <= 1'b1;
            approaching_r <= approaching_s;
        end else begin
            y_pad_r       <= y_pad_r;
            cnt_r         <= cnt_r;
            x_prev_r      <= x_prev_r;
            prev_valid_r  <= prev_valid_r;
            approaching_r <= approaching_r;
        end
    end

    assign y_pad    = y_pad_r;
    assign ai_state = state_r;

endmodule
